// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. The frame format (5-8 data bits, parity,
// one or two stop bits, bit period) is latched from the inputs at every pop.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstn_i,
    input  logic [15:0]                 clk_div_i,
    input  logic [1:0]                  data_bits_i,
    input  logic [1:0]                  parity_mode_i,
    input  logic                        stop2_i,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;

    logic [7:0]    data_q, data_d;
    logic [15:0]   div_q, div_d;
    logic [1:0]    bits_q, bits_d;
    logic [1:0]    par_q, par_d;
    logic          stop2_q, stop2_d;

    logic          bit_end, start_frame, par_en, par_bit;
    logic [2:0]    last_bit;
    logic [7:0]    data_mask;

    assign tx_ready_o   = (count_q < FULL_CNT);
    assign push         = tx_valid_i && tx_ready_o;
    assign fifo_count_o = count_q;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);
    assign tx_done_o    = done_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end

    // Parity covers only the bits actually sent; unused upper bits are masked off.
    assign last_bit  = 3'd4 + {1'b0, bits_q};
    assign data_mask = 8'hFF >> (2'd3 - bits_q);
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_bit   = (^(data_q & data_mask)) ^ (par_q == 2'b10);
    assign bit_end   = (baud_q == div_q);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        done_d      = 1'b0;
        data_d      = data_q;
        div_d       = div_q;
        bits_d      = bits_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) start_frame = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == last_bit) begin
                        stop_d  = 1'b0;
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        if (count_q != '0) start_frame = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new frame pops the head entry and snapshots the line configuration.
        if (start_frame) begin
            pop     = 1'b1;
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            stop_d  = 1'b0;
            data_d  = mem_q[rd_ptr_q];
            div_d   = clk_div_i;
            bits_d  = data_bits_i;
            par_d   = parity_mode_i;
            stop2_d = stop2_i;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q  <= data_d;
        div_q   <= div_d;
        bits_q  <= bits_d;
        par_q   <= par_d;
        stop2_q <= stop2_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames are queued when bytes are
// written and compared cycle by cycle against the serial line.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b1;
    logic [15:0] clk_div_i = 16'd0;
    logic [1:0]  data_bits_i = 2'b11;
    logic [1:0]  parity_mode_i = 2'b00;
    logic        stop2_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o, tx_o, busy_o, tx_done_o;
    logic [2:0]  fifo_count_o;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn_i(rstn_i), .clk_div_i(clk_div_i), .data_bits_i(data_bits_i),
        .parity_mode_i(parity_mode_i), .stop2_i(stop2_i), .tx_data_i(tx_data_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_o(tx_o), .busy_o(busy_o),
        .tx_done_o(tx_done_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          div;
    } frame_t;

    frame_t sb_q[$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always @(negedge clk) if (tx_done_o === 1'b1) done_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic frame_t mk_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] pm, input logic s2, input int div);
        frame_t f;
        int n, k;
        logic p;
        n = 5 + int'(db);
        f.bits = '1;
        f.div = div;
        k = 0;
        p = 1'b0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (pm == 2'b01) begin f.bits[k] = p; k++; end
        else if (pm == 2'b10) begin f.bits[k] = ~p; k++; end
        f.bits[k] = 1'b1; k++;
        if (s2) begin f.bits[k] = 1'b1; k++; end
        f.nbits = k;
        return f;
    endfunction

    // Waits (bounded) for a start bit, then records one sample per clock for the
    // length of the expected frame at the head of the scoreboard.
    task automatic rx_frame(output logic [0:63] smp, output logic [0:63] exp,
                            output int wait_c, output bit ok);
        frame_t f;
        int len;
        smp = '0;
        exp = '0;
        wait_c = 0;
        ok = 1'b1;
        while (1) begin
            @(negedge clk);
            if (tx_o === 1'b0) break;
            wait_c++;
            if (wait_c > 500) begin ok = 1'b0; return; end
        end
        if (sb_q.size() == 0) begin ok = 1'b0; return; end
        f = sb_q.pop_front();
        len = f.nbits * (f.div + 1);
        for (int i = 0; i < len; i++) exp[i] = f.bits[i / (f.div + 1)];
        smp[0] = tx_o;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            smp[i] = tx_o;
        end
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [1:0] db,
                           input logic [1:0] pm, input logic s2);
        clk_div_i = div;
        data_bits_i = db;
        parity_mode_i = pm;
        stop2_i = s2;
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_data_i = d;
        tx_valid_i = 1'b1;
        @(posedge clk); #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        #1 rstn_i = 1'b0;
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (tx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done_o); end
        checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
        checks++; if (tx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready_o); end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=1 busy=0", tx_o, busy_o);
        end
    endtask

    task automatic test_8n1;
        logic [0:63] smp, exp;
        int w, d0;
        bit ok;
        set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
        @(posedge clk); #1;
        d0 = done_cnt;
        sb_q.push_back(mk_frame(8'hA5, 2'b11, 2'b00, 1'b0, 3));
        push_byte(8'hA5);
        checks++; if (fifo_count_o !== 3'd1 || tx_o !== 1'b1) begin
            errors++; $display("FAIL 8n1_push: got count=%0d tx=%b want count=1 tx=1", fifo_count_o, tx_o);
        end
        rx_frame(smp, exp, w, ok);
        checks++; if (!ok || smp !== exp) begin
            errors++; $display("FAIL 8n1_frame: got %h want %h ok=%0b", smp, exp, ok);
        end
        checks++; if (w !== 1) begin errors++; $display("FAIL 8n1_latency: got %0d idle cycles want 1", w); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL 8n1_early_done: got %0d pulses want 0", done_cnt - d0); end
        @(negedge clk); #1;
        checks++; if (tx_done_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++; $display("FAIL 8n1_end: got done=%b busy=%b tx=%b want 1 0 1", tx_done_o, busy_o, tx_o);
        end
        @(negedge clk); #1;
        checks++; if (tx_done_o !== 1'b0 || done_cnt !== d0 + 1) begin
            errors++; $display("FAIL 8n1_done_pulse: got done=%b pulses=%0d want 0 and 1", tx_done_o, done_cnt - d0);
        end
    endtask

    task automatic test_parity;
        logic [0:63] smp, exp;
        int w;
        bit ok;
        set_cfg(16'd0, 2'b10, 2'b01, 1'b1);
        @(posedge clk); #1;
        sb_q.push_back(mk_frame(8'h7F, 2'b10, 2'b01, 1'b1, 0));
        push_byte(8'h7F);
        rx_frame(smp, exp, w, ok);
        checks++; if (!ok || smp !== exp) begin
            errors++; $display("FAIL even_frame: got %h want %h ok=%0b", smp, exp, ok);
        end
        checks++; if (smp[8] !== 1'b1) begin errors++; $display("FAIL even_parity_bit: got %b want 1", smp[8]); end
        repeat (3) @(posedge clk); #1;
        parity_mode_i = 2'b10;
        sb_q.push_back(mk_frame(8'h03, 2'b10, 2'b10, 1'b1, 0));
        push_byte(8'h03);
        rx_frame(smp, exp, w, ok);
        checks++; if (!ok || smp !== exp) begin
            errors++; $display("FAIL odd_frame: got %h want %h ok=%0b", smp, exp, ok);
        end
        checks++; if (smp[8] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit: got %b want 1", smp[8]); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        int d0;
        set_cfg(16'd1, 2'b11, 2'b00, 1'b0);
        @(posedge clk); #1;
        d0 = done_cnt;
        fork
            begin
                // Pop happens with the 2nd write, so writes 1-5 fit and the 6th finds the FIFO full.
                for (int c = 0; c < 6; c++) begin
                    if (c <= 4) sb_q.push_back(mk_frame(8'h31 + 8'(c), 2'b11, 2'b00, 1'b0, 1));
                    tx_data_i = 8'h31 + 8'(c);
                    tx_valid_i = 1'b1;
                    @(posedge clk); #1;
                    if (c == 1) begin
                        checks++; if (fifo_count_o !== 3'd1) begin
                            errors++; $display("FAIL b2b_push_pop: got count %0d want 1", fifo_count_o);
                        end
                    end
                    if (c == 4) begin
                        checks++; if (fifo_count_o !== 3'd4 || tx_ready_o !== 1'b0) begin
                            errors++; $display("FAIL b2b_full: got count=%0d ready=%b want 4 0", fifo_count_o, tx_ready_o);
                        end
                    end
                    if (c == 5) begin
                        checks++; if (fifo_count_o !== 3'd4) begin
                            errors++; $display("FAIL b2b_drop: got count %0d want 4", fifo_count_o);
                        end
                    end
                end
                tx_valid_i = 1'b0;
            end
            begin
                logic [0:63] smp, exp;
                int w;
                bit ok;
                for (int i = 0; i < 5; i++) begin
                    rx_frame(smp, exp, w, ok);
                    checks++; if (!ok || smp !== exp) begin
                        errors++; $display("FAIL b2b_frame%0d: got %h want %h ok=%0b", i, smp, exp, ok);
                    end
                    if (i > 0) begin
                        checks++; if (w !== 0) begin
                            errors++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 0", i, w);
                        end
                    end
                end
            end
        join
        @(negedge clk); #1;
        checks++; if (done_cnt !== d0 + 5 || fifo_count_o !== 3'd0) begin
            errors++; $display("FAIL b2b_end: got pulses=%0d count=%0d want 5 0", done_cnt - d0, fifo_count_o);
        end
    endtask

    task automatic test_midframe_cfg;
        set_cfg(16'd1, 2'b11, 2'b00, 1'b0);
        @(posedge clk); #1;
        sb_q.push_back(mk_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1));
        sb_q.push_back(mk_frame(8'hC3, 2'b00, 2'b00, 1'b0, 1));
        fork
            begin
                push_byte(8'h5A);
                push_byte(8'hC3);
                repeat (8) @(posedge clk);
                #1 data_bits_i = 2'b00;
            end
            begin
                logic [0:63] smp, exp;
                int w;
                bit ok;
                rx_frame(smp, exp, w, ok);
                checks++; if (!ok || smp !== exp) begin
                    errors++; $display("FAIL cfg_frame8: got %h want %h ok=%0b", smp, exp, ok);
                end
                rx_frame(smp, exp, w, ok);
                checks++; if (!ok || smp !== exp || w !== 0) begin
                    errors++; $display("FAIL cfg_frame5: got %h gap %0d want %h gap 0", smp, w, exp);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1 data_bits_i = 2'b11;
    endtask

    task automatic test_reset_midframe;
        bit bad;
        set_cfg(16'd3, 2'b11, 2'b00, 1'b0);
        @(posedge clk); #1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b1 || fifo_count_o !== 3'd3) begin
            errors++; $display("FAIL rst_pre: got busy=%b count=%0d want 1 3", busy_o, fifo_count_o);
        end
        rstn_i = 1'b0;
        #2;
        checks++; if (tx_o !== 1'b1 || fifo_count_o !== 3'd0 || busy_o !== 1'b0 || tx_ready_o !== 1'b1 || tx_done_o !== 1'b0) begin
            errors++; $display("FAIL rst_async: got tx=%b count=%0d busy=%b ready=%b done=%b want 1 0 0 1 0",
                               tx_o, fifo_count_o, busy_o, tx_ready_o, tx_done_o);
        end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_count_o !== 3'd0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rst_stale: got line activity after reset, want idle"); end
    endtask

    task automatic test_full_wrap;
        int d0;
        set_cfg(16'd0, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        d0 = done_cnt;
        fork
            begin
                // 7-cycle frames: pops at writes 1, 8 and 15. Writes 5-7 hit a full
                // FIFO, write 8 coincides with a pop while full, write 9 fits again.
                for (int c = 0; c < 10; c++) begin
                    if (c <= 4 || c == 9) sb_q.push_back(mk_frame(8'hE0 + 8'(c), 2'b00, 2'b00, 1'b0, 0));
                    tx_data_i = 8'hE0 + 8'(c);
                    tx_valid_i = 1'b1;
                    @(posedge clk); #1;
                    if (c == 4) begin
                        checks++; if (fifo_count_o !== 3'd4 || tx_ready_o !== 1'b0) begin
                            errors++; $display("FAIL wrap_full: got count=%0d ready=%b want 4 0", fifo_count_o, tx_ready_o);
                        end
                    end
                    if (c == 7) begin
                        checks++; if (fifo_count_o !== 3'd4) begin
                            errors++; $display("FAIL wrap_hold: got count %0d want 4", fifo_count_o);
                        end
                    end
                    if (c == 8) begin
                        checks++; if (fifo_count_o !== 3'd3) begin
                            errors++; $display("FAIL wrap_pop_full: got count %0d want 3", fifo_count_o);
                        end
                    end
                    if (c == 9) begin
                        checks++; if (fifo_count_o !== 3'd4) begin
                            errors++; $display("FAIL wrap_refill: got count %0d want 4", fifo_count_o);
                        end
                    end
                end
                tx_valid_i = 1'b0;
            end
            begin
                logic [0:63] smp, exp;
                int w;
                bit ok;
                for (int i = 0; i < 6; i++) begin
                    rx_frame(smp, exp, w, ok);
                    checks++; if (!ok || smp !== exp || (i > 0 && w !== 0)) begin
                        errors++; $display("FAIL wrap_frame%0d: got %h gap %0d want %h ok=%0b", i, smp, w, exp, ok);
                    end
                end
            end
        join
        @(negedge clk); #1;
        checks++; if (done_cnt !== d0 + 6 || fifo_count_o !== 3'd0) begin
            errors++; $display("FAIL wrap_end: got pulses=%0d count=%0d want 6 0", done_cnt - d0, fifo_count_o);
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_back_to_back;
        test_midframe_cfg;
        test_reset_midframe;
        test_full_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
